// File: rtl/shift_out_chain.sv
// Serial driver for external shift/latch register chains (74HC595 style).
// A one-word holding buffer lets the next word load while the current one shifts.
module shift_out_chain #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 1,
    parameter int LSB_FIRST  = 0,
    parameter int AUTO_START = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      action_pulse,
    input  logic                      action_clk,
    input  logic                      load_valid,
    input  logic [WIDTH*CHANNELS-1:0] load_data,
    output logic                      load_ready,
    input  logic                      go,
    output logic                      shift_clk,
    output logic [CHANNELS-1:0]       serial_data_out,
    output logic                      write_load_clk,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             counter;
    logic [CW-1:0]             counter_nxt;
    logic [WIDTH*CHANNELS-1:0] shifter;
    logic [WIDTH*CHANNELS-1:0] shifter_nxt;
    logic [WIDTH*CHANNELS-1:0] shifted;
    logic [WIDTH*CHANNELS-1:0] hold_data;
    logic                      hold_valid;
    logic                      load_accept;
    logic                      start;
    logic                      done_nxt;

    // Load handshake: a word transfers on any clk where load_valid && load_ready;
    // load_valid may be held, and load_ready only depends on the buffer being empty.
    assign load_ready  = !hold_valid;
    assign load_accept = load_valid && load_ready;
    assign start       = action_pulse && (state == IDLE) && hold_valid &&
                         (go || (AUTO_START != 0));

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Each channel moves one bit toward its output end, zero fill behind.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        if (LSB_FIRST != 0) begin : g_lsb
            assign shifted[c*WIDTH +: WIDTH] = {1'b0, shifter[c*WIDTH+1 +: WIDTH-1]};
            assign serial_data_out[c]        = shifter[c*WIDTH];
        end else begin : g_msb
            assign shifted[c*WIDTH +: WIDTH] = {shifter[c*WIDTH +: WIDTH-1], 1'b0};
            assign serial_data_out[c]        = shifter[c*WIDTH + WIDTH-1];
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        shifter_nxt = shifter;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SHIFT;
                    shifter_nxt = hold_data;
                    counter_nxt = CW'(1);
                end
            end
            SHIFT: begin
                if (action_pulse) begin
                    shifter_nxt = shifted;
                    // The final shift empties the shifter, so the data line idles low.
                    if (counter == CW'(WIDTH)) begin
                        state_nxt   = LATCH;
                        counter_nxt = '0;
                    end else begin
                        counter_nxt = counter + CW'(1);
                    end
                end
            end
            LATCH: begin
                if (action_pulse) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
                shifter_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            shifter <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            shifter <= shifter_nxt;
            done    <= done_nxt;
        end
    end

    // Start and load never coincide: start needs a full buffer, load needs an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (load_accept) begin
            hold_valid <= 1'b1;
            hold_data  <= load_data;
        end else if (start) begin
            hold_valid <= 1'b0;
        end
    end

    // Registered so the chain clocks rise a clk after the data bit settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_clk      <= 1'b0;
            write_load_clk <= 1'b0;
        end else begin
            shift_clk      <= action_clk && (state == SHIFT);
            write_load_clk <= (state == LATCH);
        end
    end

endmodule

// File: tb/tb_shift_out_chain.sv
// Directed bench for shift_out_chain: three configurations (MSB-first dual channel,
// LSB-first, auto-start) sharing one clock and action timebase.
`timescale 1ns/1ps
module tb_shift_out_chain;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Action timebase: 16 clks per period, pulse one clk before action_clk rises.
    int   act_cnt = 0;
    logic action_pulse;
    logic action_clk;
    always @(posedge clk) act_cnt <= (act_cnt + 1) % 16;
    assign action_pulse = (act_cnt == 0);
    assign action_clk   = (act_cnt >= 1) && (act_cnt <= 8);

    // Instance A: W=8, C=2, MSB first
    logic        a_valid, a_go, a_ready, a_sclk, a_wlc, a_busy, a_done;
    logic [15:0] a_data;
    logic [1:0]  a_sdo, a_st;
    // Instance B: W=8, C=1, LSB first
    logic        b_valid, b_go, b_ready, b_sclk, b_wlc, b_busy, b_done;
    logic [7:0]  b_data;
    logic [0:0]  b_sdo;
    logic [1:0]  b_st;
    // Instance C: W=8, C=1, auto start
    logic        c_valid, c_go, c_ready, c_sclk, c_wlc, c_busy, c_done;
    logic [7:0]  c_data;
    logic [0:0]  c_sdo;
    logic [1:0]  c_st;

    shift_out_chain #(.WIDTH(8), .CHANNELS(2), .LSB_FIRST(0), .AUTO_START(0)) u_a (
        .clk(clk), .reset(reset), .action_pulse(action_pulse), .action_clk(action_clk),
        .load_valid(a_valid), .load_data(a_data), .load_ready(a_ready), .go(a_go),
        .shift_clk(a_sclk), .serial_data_out(a_sdo), .write_load_clk(a_wlc),
        .busy(a_busy), .done(a_done), .state_dbg(a_st));

    shift_out_chain #(.WIDTH(8), .CHANNELS(1), .LSB_FIRST(1), .AUTO_START(0)) u_b (
        .clk(clk), .reset(reset), .action_pulse(action_pulse), .action_clk(action_clk),
        .load_valid(b_valid), .load_data(b_data), .load_ready(b_ready), .go(b_go),
        .shift_clk(b_sclk), .serial_data_out(b_sdo), .write_load_clk(b_wlc),
        .busy(b_busy), .done(b_done), .state_dbg(b_st));

    shift_out_chain #(.WIDTH(8), .CHANNELS(1), .LSB_FIRST(0), .AUTO_START(1)) u_c (
        .clk(clk), .reset(reset), .action_pulse(action_pulse), .action_clk(action_clk),
        .load_valid(c_valid), .load_data(c_data), .load_ready(c_ready), .go(c_go),
        .shift_clk(c_sclk), .serial_data_out(c_sdo), .write_load_clk(c_wlc),
        .busy(c_busy), .done(c_done), .state_dbg(c_st));

    // Scoreboard state
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];

    // Chain-side monitor state, indexed by instance
    int         cyc = 0;
    int         rises[3], wlc_rises[3], wlc_len[3], done_len[3], overlap[3];
    logic [7:0] cap0[3], cap1[3];
    logic       p_sclk[3], p_wlc[3], p_busy[3];
    int         starts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int s, input logic sc, input logic wl, input logic dn,
                       input logic bz, input logic d0, input logic d1);
        if (sc && !p_sclk[s]) begin
            rises[s]++;
            cap0[s] = {cap0[s][6:0], d0};
            cap1[s] = {cap1[s][6:0], d1};
        end
        if (wl && !p_wlc[s]) wlc_rises[s]++;
        if (wl) wlc_len[s]++;
        if (dn) done_len[s]++;
        if (wl && sc) overlap[s]++;
        if (bz && !p_busy[s] && s == 0) starts.push_back(cyc);
        p_sclk[s] = sc;
        p_wlc[s]  = wl;
        p_busy[s] = bz;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, a_sclk, a_wlc, a_done, a_busy, a_sdo[0], a_sdo[1]);
        mon(1, b_sclk, b_wlc, b_done, b_busy, b_sdo[0], 1'b0);
        mon(2, c_sclk, c_wlc, c_done, c_busy, c_sdo[0], 1'b0);
    end

    task automatic clear_mon(input int s);
        rises[s] = 0; wlc_rises[s] = 0; wlc_len[s] = 0; done_len[s] = 0; overlap[s] = 0;
        cap0[s] = '0; cap1[s] = '0;
        if (s == 0) starts.delete();
    endtask

    function automatic logic ready_of(input int s);
        case (s)
            0:       return a_ready;
            1:       return b_ready;
            default: return c_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    task automatic set_go(input int s, input logic v);
        case (s)
            0:       a_go = v;
            1:       b_go = v;
            default: c_go = 1'b0;
        endcase
    endtask

    task automatic set_load(input int s, input logic v, input logic [15:0] d);
        case (s)
            0:       begin a_valid = v; a_data = d; end
            1:       begin b_valid = v; b_data = d[7:0]; end
            default: begin c_valid = v; c_data = d[7:0]; end
        endcase
    endtask

    // Driver: present a word, hold until accepted, then withdraw.
    task automatic load(input int s, input logic [15:0] d);
        int t = 0;
        set_load(s, 1'b1, d);
        while (!ready_of(s) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("load_accept_timeout", 32'(t < 500), 32'd1);
        @(negedge clk);
        set_load(s, 1'b0, d);
    endtask

    task automatic wait_start(input int s);
        int t = 0;
        while (!busy_of(s) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("start_latency", 32'(t >= 1 && t <= 16), 32'd1);
    endtask

    task automatic wait_rises(input int s, input int n);
        int t = 0;
        while (rises[s] < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rise_wait_timeout", 32'(t < 500), 32'd1);
    endtask

    task automatic wait_done(input int s, input int n);
        int t = 0;
        while (done_len[s] < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t < 600), 32'd1);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        clear_mon(v.sel);
        exp_q.push_back(v.exp0);
        exp_q.push_back(v.exp1);
        set_go(v.sel, 1'b1);
        load(v.sel, v.data);
        wait_start(v.sel);
        wait_done(v.sel, 1);
        repeat (3) @(negedge clk);
        set_go(v.sel, 1'b0);
        chk("bits_ch0", 32'(cap0[v.sel]), 32'(exp_q.pop_front()));
        chk("bits_ch1", 32'(cap1[v.sel]), 32'(exp_q.pop_front()));
        chk("shift_rises", rises[v.sel], 8);
        chk("latch_pulses", wlc_rises[v.sel], 1);
        chk("latch_width", wlc_len[v.sel], 16);
        chk("done_width", done_len[v.sel], 1);
        chk("latch_overlap", overlap[v.sel], 0);
        chk("busy_after", 32'(busy_of(v.sel)), 32'd0);
        chk("ready_after", 32'(ready_of(v.sel)), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h000F, 8'h0F, 8'h00};
        vecs[1] = '{0, 16'hF03C, 8'h3C, 8'hF0};
        vecs[2] = '{0, 16'hA55A, 8'h5A, 8'hA5};
        vecs[3] = '{1, 16'h000F, 8'hF0, 8'h00};
        vecs[4] = '{1, 16'h0081, 8'h81, 8'h00};
        vecs[5] = '{1, 16'h0036, 8'h6C, 8'h00};
        vecs[6] = '{2, 16'h00A5, 8'hA5, 8'h00};
        vecs[7] = '{2, 16'h0001, 8'h01, 8'h00};

        a_valid = 0; a_go = 0; a_data = '0;
        b_valid = 0; b_go = 0; b_data = '0;
        c_valid = 0; c_go = 0; c_data = '0;
        for (int s = 0; s < 3; s++) begin
            p_sclk[s] = 0; p_wlc[s] = 0; p_busy[s] = 0;
            clear_mon(s);
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready_a", 32'(a_ready), 32'd1);
        chk("rst_outs_a", 32'({a_sclk, a_sdo, a_wlc, a_busy, a_done}), 32'd0);
        chk("rst_state_a", 32'(a_st), 32'd0);
        chk("rst_outs_b", 32'({b_sclk, b_sdo, b_wlc, b_busy, b_done, b_ready}), 32'd1);
        chk("rst_outs_c", 32'({c_sclk, c_sdo, c_wlc, c_busy, c_done, c_ready}), 32'd1);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Table-driven single transfers
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: second word loads mid-shift, third stalls
        clear_mon(0);
        a_go = 1'b1;
        load(0, 16'h0011);
        wait_start(0);
        wait_rises(0, 3);
        chk("b2b_ready_mid", 32'(a_ready), 32'd1);
        load(0, 16'h0022);
        chk("b2b_ready_full", 32'(a_ready), 32'd0);
        a_valid = 1'b1;
        a_data  = 16'h0033;
        repeat (20) @(negedge clk);
        chk("b2b_third_stalls", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        wait_done(0, 2);
        repeat (200) @(negedge clk);
        chk("b2b_bits", 32'(cap0[0]), 32'h22);
        chk("b2b_rises", rises[0], 16);
        chk("b2b_latches", wlc_rises[0], 2);
        chk("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) chk("b2b_period", starts[1] - starts[0], 160);
        a_go = 1'b0;

        // Reset mid-transfer with a word buffered
        clear_mon(0);
        a_go = 1'b1;
        load(0, 16'h00FF);
        wait_start(0);
        wait_rises(0, 3);
        load(0, 16'h0055);
        chk("abort_buffer_full", 32'(a_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_outs", 32'({a_sclk, a_sdo, a_wlc, a_busy, a_done}), 32'd0);
        chk("abort_ready", 32'(a_ready), 32'd1);
        chk("abort_state", 32'(a_st), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_mon(0);
        repeat (200) @(negedge clk);
        chk("abort_no_latch", wlc_rises[0], 0);
        chk("abort_buffer_dropped", starts.size(), 0);
        a_go = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
